// File: rtl/feature_weight_seq_counter.sv
// feature_weight_seq_counter: step counter 0..MAX_CNT driving the MAC datapath decoders, with stall/abort and a done pulse.
module feature_weight_seq_counter #(
  parameter int CNT_W = 5,
  parameter int MAX_CNT = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             abort,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_valid,
  output logic             last,
  output logic             busy,
  output logic             done
);
  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10;
  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [1:0] state, state_n;
  logic [CNT_W-1:0] cnt_n;
  assign cnt_valid = state == RUN;
  assign last = cnt_valid && cnt == MAX;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // DONE and the illegal encoding both fall through to IDLE with cnt cleared
  always_comb begin
    state_n = state == IDLE ? (start ? RUN : IDLE)
            : state == RUN  ? (abort ? IDLE : stall ? RUN : last ? DONE : RUN)
            : IDLE;
    cnt_n = (!cnt_valid || abort || (last && !stall)) ? '0 : stall ? cnt : cnt + ONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_feature_weight_seq_counter.sv
// tb_feature_weight_seq_counter: directed checks of sequencing, stall, abort, ignored inputs and reset.
module tb_feature_weight_seq_counter;
  logic clk = 0, rst = 1, start = 0, stall = 0, abort = 0;
  logic [4:0] cnt;
  logic cnt_valid, last, busy, done;
  int total = 0, bad = 0;
  feature_weight_seq_counter dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .abort(abort),
    .cnt(cnt), .cnt_valid(cnt_valid), .last(last), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  function automatic logic [8:0] e(int c, bit v, bit l, bit b, bit d);
    logic [4:0] cc;
    cc = 5'(c);
    return {cc, v, l, b, d};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [8:0] expv);
    logic [8:0] obs;
    obs = {cnt, cnt_valid, last, busy, done};
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  initial begin
    tick(); tick();
    chk("reset", e(0, 0, 0, 0, 0));
    rst = 0;
    for (int i = 0; i < 10; i++) begin tick(); chk("idle", e(0, 0, 0, 0, 0)); end
    start = 1; tick(); start = 0;
    chk("run0", e(0, 1, 0, 1, 0));
    for (int i = 1; i <= 24; i++) begin tick(); chk("run", e(i, 1, i == 24, 1, 0)); end
    tick(); chk("done", e(0, 0, 0, 1, 1));
    tick(); chk("back_idle", e(0, 0, 0, 0, 0));
    start = 1; tick(); start = 0;
    chk("s_run0", e(0, 1, 0, 1, 0));
    for (int i = 1; i <= 5; i++) tick();
    chk("s_at5", e(5, 1, 0, 1, 0));
    start = 1; tick(); start = 0;
    chk("start_in_run", e(6, 1, 0, 1, 0));
    tick(); chk("s_at7", e(7, 1, 0, 1, 0));
    stall = 1;
    for (int i = 0; i < 3; i++) begin tick(); chk("stall7", e(7, 1, 0, 1, 0)); end
    stall = 0;
    for (int i = 8; i <= 24; i++) tick();
    chk("s_at24", e(24, 1, 1, 1, 0));
    stall = 1;
    for (int i = 0; i < 2; i++) begin tick(); chk("stall24", e(24, 1, 1, 1, 0)); end
    stall = 0; start = 1; tick(); start = 1;
    chk("s_done", e(0, 0, 0, 1, 1));
    tick(); start = 0;
    chk("start_in_done", e(0, 0, 0, 0, 0));
    tick(); chk("idle_after_done", e(0, 0, 0, 0, 0));
    start = 1; tick(); start = 0;
    for (int i = 1; i <= 12; i++) tick();
    chk("a_at12", e(12, 1, 0, 1, 0));
    abort = 1; stall = 1; tick(); abort = 0; stall = 0;
    chk("abort", e(0, 0, 0, 0, 0));
    tick(); chk("abort_no_done", e(0, 0, 0, 0, 0));
    start = 1; tick(); start = 0;
    chk("restart_after_abort", e(0, 1, 0, 1, 0));
    abort = 1; tick(); abort = 0;
    chk("abort0", e(0, 0, 0, 0, 0));
    start = 1; tick();
    chk("held_launch1", e(0, 1, 0, 1, 0));
    for (int i = 1; i <= 24; i++) tick();
    chk("held_last", e(24, 1, 1, 1, 0));
    tick(); chk("held_done", e(0, 0, 0, 1, 1));
    tick(); chk("held_idle", e(0, 0, 0, 0, 0));
    tick(); chk("held_launch2", e(0, 1, 0, 1, 0));
    start = 0;
    for (int i = 1; i <= 18; i++) tick();
    chk("r_at18", e(18, 1, 0, 1, 0));
    rst = 1; tick(); rst = 0;
    chk("mid_reset", e(0, 0, 0, 0, 0));
    tick(); chk("mid_reset_no_done", e(0, 0, 0, 0, 0));
    start = 1; tick(); start = 0;
    chk("post_rst_run0", e(0, 1, 0, 1, 0));
    for (int i = 1; i <= 24; i++) begin tick(); chk("post_rst_run", e(i, 1, i == 24, 1, 0)); end
    tick(); chk("post_rst_done", e(0, 0, 0, 1, 1));
    tick(); chk("post_rst_idle", e(0, 0, 0, 0, 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
